pwm_capture: RTL and testbench

- Receive-side counterpart of the board's ramp PWM generator: samples an external PWM waveform and measures period and high time in clk_50 cycles.
- Converts the measurement to a PWM_BITS duty code, duty = floor(high * 2^PWM_BITS / period), using a sequential restoring divider.
- Used for loopback checking of the generator output and for reading external PWM sources; results are issued as single-cycle valid pulses.

---
 rtl/pwm_capture.sv | 172 +++++++++++++++++
 tb/tb_pwm_capture.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an external PWM waveform in
// clk_50 cycles and converts them to a PWM_BITS duty code with a restoring
// divider. Results, including the no-signal timeout result, are issued with
// a single-cycle duty_valid pulse and held until the next one.
module pwm_capture #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int PWM_BITS    = 10,
  parameter int CNT_W       = 20,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic                clk_50,
  input  logic                rst_n,
  input  logic                pwm_in,
  output logic [PWM_BITS-1:0] duty_out,
  output logic [CNT_W-1:0]    period_out,
  output logic [CNT_W-1:0]    high_out,
  output logic                duty_valid,
  output logic                no_signal,
  output logic                overrun
);

  localparam int IT_W = $clog2(PWM_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT_CYC);

  // CLK_HZ only documents the intended clock; it takes part in the sanity check
  localparam bit CFG_OK = (CLK_HZ > 0) && (TIMEOUT_CYC > PWM_BITS + 3) &&
                          (longint'(TIMEOUT_CYC) < (longint'(1) << CNT_W));

  generate
    if (!CFG_OK) begin : g_cfg_err
      $error("pwm_capture: parameter set out of range");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ARMED, DIV, DONE} state_t;

  state_t              state, state_nxt;
  logic                s1, s2, s3;
  logic                rise, timeout;
  logic [CNT_W-1:0]    cnt, hcnt;
  logic [CNT_W:0]      rem;
  logic [CNT_W-1:0]    dvsr, hcap;
  logic [PWM_BITS-1:0] quo;
  logic [IT_W-1:0]     iter;
  logic                capture, drop, load;
  logic [CNT_W+1:0]    rem2;
  logic [CNT_W:0]      rem_nxt;
  logic                ge;

  assign rise    = s2 & ~s3;
  // a rise in the same cycle takes priority over the timeout
  assign timeout = (cnt == TO_VAL) & ~rise;

  // three-flop synchroniser; s3 is the delayed copy for edge detection
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // period and high counters; reload to 1 on a rise so a steady waveform
  // yields exactly P and H, both saturate so a dead input cannot wrap
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      hcnt <= '0;
    end else if (rise) begin
      cnt  <= CNT_W'(1);
      hcnt <= CNT_W'(1);
    end else begin
      if (cnt != CNT_MAX)        cnt  <= cnt + CNT_W'(1);
      if (s2 && hcnt != CNT_MAX) hcnt <= hcnt + CNT_W'(1);
    end
  end

  // state register
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state and per-cycle control strobes
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    drop      = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE:  if (rise) state_nxt = ARMED;
      ARMED: if (rise) begin
               state_nxt = DIV;
               capture   = 1'b1;
             end
      DIV:   begin
               drop = rise;
               if (iter == IT_W'(1)) state_nxt = DONE;
             end
      DONE:  begin
               drop      = rise;
               load      = ~timeout;
               state_nxt = ARMED;
             end
      default: state_nxt = IDLE;
    endcase
    if (timeout) state_nxt = IDLE;
  end

  // one restoring-division step: shift remainder, subtract if it fits
  always_comb begin
    rem2    = {rem, 1'b0};
    ge      = rem2 >= {2'b00, dvsr};
    rem_nxt = ge ? (CNT_W+1)'(rem2 - {2'b00, dvsr}) : rem2[CNT_W:0];
  end

  // divider datapath: loaded on capture, iterates while in DIV
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      rem  <= '0;
      dvsr <= '0;
      hcap <= '0;
      quo  <= '0;
      iter <= '0;
    end else if (capture) begin
      rem  <= {1'b0, hcnt};
      dvsr <= cnt;
      hcap <= hcnt;
      quo  <= '0;
      iter <= IT_W'(PWM_BITS);
    end else if (state == DIV) begin
      rem  <= rem_nxt;
      quo  <= {quo[PWM_BITS-2:0], ge};
      iter <= iter - IT_W'(1);
    end
  end

  // result registers, valid pulse and sticky overrun. high never exceeds
  // period, so the quotient tops out at all ones and needs no extra clamp.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      duty_out   <= '0;
      period_out <= '0;
      high_out   <= '0;
      duty_valid <= 1'b0;
      no_signal  <= 1'b1;
      overrun    <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      if (timeout) begin
        duty_out   <= {PWM_BITS{s2}};
        period_out <= '0;
        high_out   <= '0;
        no_signal  <= 1'b1;
        duty_valid <= 1'b1;
      end else if (load) begin
        duty_out   <= quo;
        period_out <= dvsr;
        high_out   <= hcap;
        no_signal  <= 1'b0;
        duty_valid <= 1'b1;
      end
      if (drop) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed sequence with randomized PWM periods, checked
// against a reference built from (period, high) pairs and rise timestamps.
module tb_pwm_capture;

  localparam int PB = 10;
  localparam int CW = 20;
  localparam int TO = 5000;

  logic          clk_50 = 1'b0;
  logic          rst_n;
  logic          pwm_in;
  logic [PB-1:0] duty_out;
  logic [CW-1:0] period_out, high_out;
  logic          duty_valid, no_signal, overrun;

  pwm_capture #(.CLK_HZ(50_000_000), .PWM_BITS(PB), .CNT_W(CW), .TIMEOUT_CYC(TO)) dut (
    .clk_50(clk_50), .rst_n(rst_n), .pwm_in(pwm_in),
    .duty_out(duty_out), .period_out(period_out), .high_out(high_out),
    .duty_valid(duty_valid), .no_signal(no_signal), .overrun(overrun)
  );

  always #10 clk_50 = ~clk_50;

  typedef struct {int c; int duty; int per; int hi; int ns;} rec_t;

  int   cyc = 0;
  rec_t recs[$];
  int   rises[$];
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk_50) cyc <= cyc + 1;

  // log every result pulse with its cycle stamp
  always @(negedge clk_50)
    if (duty_valid)
      recs.push_back('{cyc, int'(duty_out), int'(period_out), int'(high_out), int'(no_signal)});

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_duty(input int p, input int h);
    longint v;
    v = (longint'(h) * (longint'(1) << PB)) / p;
    return (v > (1 << PB) - 1) ? (1 << PB) - 1 : int'(v);
  endfunction

  // one PWM period starting at a negedge: high for h cycles, low for p-h
  task automatic pulse(input int p, input int h);
    pwm_in = 1'b1;
    rises.push_back(cyc);
    repeat (h) @(negedge clk_50);
    pwm_in = 1'b0;
    repeat (p - h) @(negedge clk_50);
  endtask

  task automatic chk_capture(input string tag, input rec_t r, input int rc, input int p, input int h);
    chk({tag, "_cyc"},  r.c,    rc + PB + 4);
    chk({tag, "_duty"}, r.duty, ref_duty(p, h));
    chk({tag, "_per"},  r.per,  p);
    chk({tag, "_hi"},   r.hi,   h);
    chk({tag, "_ns"},   r.ns,   0);
  endtask

  task automatic chk_timeout(input string tag, input rec_t r, input int rc, input int duty);
    chk({tag, "_cyc"},  r.c,    rc + TO + 3);
    chk({tag, "_duty"}, r.duty, duty);
    chk({tag, "_per"},  r.per,  0);
    chk({tag, "_hi"},   r.hi,   0);
    chk({tag, "_ns"},   r.ns,   1);
  endtask

  initial begin
    int P[6];
    int H[6];
    int n;

    // reset state
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk_50);
    chk("rst_duty", int'(duty_out), 0);
    chk("rst_per", int'(period_out), 0);
    chk("rst_hi", int'(high_out), 0);
    chk("rst_valid", int'(duty_valid), 0);
    chk("rst_ns", int'(no_signal), 1);
    chk("rst_ovr", int'(overrun), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_50);

    // train: 1000/250, a period landing exactly on the timeout count,
    // then random periods; a closing rise followed by silence times out low
    P[0] = 1000; H[0] = 250;
    P[1] = TO;   H[1] = $urandom_range(1, TO - 1);
    for (int i = 2; i < 6; i++) begin
      P[i] = $urandom_range(30, 400);
      H[i] = $urandom_range(1, P[i] - 1);
    end
    recs.delete(); rises.delete();
    for (int i = 0; i < 6; i++) pulse(P[i], H[i]);
    pulse(TO + 200, 10);
    chk("train_count", recs.size(), 7);
    n = (recs.size() < 6) ? recs.size() : 6;
    for (int i = 0; i < n; i++) chk_capture($sformatf("cap%0d", i), recs[i], rises[i+1], P[i], H[i]);
    if (recs.size() > 0) chk_timeout("to_low", recs[recs.size()-1], rises[6], 0);
    chk("train_ovr", int'(overrun), 0);
    chk("train_ns_level", int'(no_signal), 1);

    // input stuck high after a rise: one timeout reporting full duty
    recs.delete(); rises.delete();
    pwm_in = 1'b1;
    rises.push_back(cyc);
    repeat (TO + 100) @(negedge clk_50);
    chk("hi_count", recs.size(), 1);
    if (recs.size() > 0) chk_timeout("to_high", recs[0], rises[0], (1 << PB) - 1);

    // rises every 3 cycles: divider busy, edges dropped, overrun sticks
    pwm_in = 1'b0;
    repeat (5) @(negedge clk_50);
    recs.delete(); rises.delete();
    repeat (20) pulse(3, 1);
    repeat (TO + 100) @(negedge clk_50);
    chk("ovr_flag", int'(overrun), 1);
    chk("ovr_some_caps", int'(recs.size() >= 2), 1);
    if (recs.size() > 0) chk("ovr_first_cyc", recs[0].c, rises[1] + PB + 4);
    for (int i = 0; i + 1 < recs.size(); i++) begin
      chk($sformatf("ovr_duty%0d", i), recs[i].duty, 341);
      chk($sformatf("ovr_per%0d", i), recs[i].per, 3);
      chk($sformatf("ovr_hi%0d", i), recs[i].hi, 1);
    end
    if (recs.size() > 0) chk_timeout("ovr_to", recs[recs.size()-1], rises[19], 0);

    // reset pulsed 4 cycles after a capturing rise aborts the divide
    recs.delete(); rises.delete();
    pulse(100, 30);
    pwm_in = 1'b1;
    rises.push_back(cyc);
    repeat (4) @(negedge clk_50);
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk_50);
    chk("mid_rst_duty", int'(duty_out), 0);
    chk("mid_rst_per", int'(period_out), 0);
    chk("mid_rst_ns", int'(no_signal), 1);
    chk("mid_rst_ovr", int'(overrun), 0);
    rst_n = 1'b1;
    repeat (30) @(negedge clk_50);
    chk("abort_no_valid", recs.size(), 0);
    pulse(100, 30);
    chk("first_rise_no_valid", recs.size(), 0);
    pulse(100, 30);
    chk("post_rst_count", recs.size(), 1);
    if (recs.size() > 0) chk_capture("post_rst", recs[0], rises[3], 100, 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
